// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one ALU among NUM_REQ requesters. One operation at a time is
//   accepted from a round-robin-selected requester, issued to the ALU with a
//   single-cycle load_en pulse, and after ALU_LAT cycles the ALU result is
//   captured and returned tagged with the requester index.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req_valid / req_ready       per-requester handshake (req_ready one-hot or zero)
//   req_operand_a/_b, req_opcode packed per-requester operation fields
//   alu_load_en, alu_operand_a/_b, alu_opcode   registered drive into the ALU
//   alu_out                     ALU result
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_data            owning requester and captured result
//   busy                        high whenever not idle
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 8,
  parameter int OPC_W   = 3,
  parameter int RES_W   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*OP_W-1:0]    req_operand_a,
  input  logic [NUM_REQ*OP_W-1:0]    req_operand_b,
  input  logic [NUM_REQ*OPC_W-1:0]   req_opcode,
  output logic                       alu_load_en,
  output logic [OP_W-1:0]            alu_operand_a,
  output logic [OP_W-1:0]            alu_operand_b,
  output logic [OPC_W-1:0]           alu_opcode,
  input  logic [RES_W-1:0]           alu_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [RES_W-1:0]           rsp_data,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic [CNT_W-1:0] cnt;

  // Round-robin search starting just after the previous grant, wrapping.
  // If only last_grant is valid it is reached last and re-granted.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Only combinational input-to-output path; suppressed while reset is high.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !reset)
      req_ready[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= ID_W'(NUM_REQ - 1);
      cnt           <= '0;
      alu_load_en   <= 1'b0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_opcode    <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_data      <= '0;
    end else begin
      case (state)
        // Accept the winner and latch its operation into the ALU drive registers.
        IDLE: begin
          if (found) begin
            alu_operand_a <= req_operand_a[int'(winner)*OP_W +: OP_W];
            alu_operand_b <= req_operand_b[int'(winner)*OP_W +: OP_W];
            alu_opcode    <= req_opcode[int'(winner)*OPC_W +: OPC_W];
            rsp_id        <= winner;
            last_grant    <= winner;
            alu_load_en   <= 1'b1;
            state         <= ISSUE;
          end
        end
        // load_en is high throughout this single cycle.
        ISSUE: begin
          alu_load_en <= 1'b0;
          cnt         <= CNT_W'(ALU_LAT);
          state       <= WAIT;
        end
        // Count down the ALU latency; alu_out is valid in the count==1 cycle.
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_data  <= alu_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        // Hold the response until it is taken.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
  localparam int N     = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A (ALU_LAT=1) ----------------
  logic        a_reset;
  logic [3:0]  a_req_valid, a_req_ready;
  logic [31:0] a_opa, a_opb;
  logic [11:0] a_opc;
  logic        a_load_en;
  logic [7:0]  a_alu_a, a_alu_b;
  logic [2:0]  a_alu_op;
  logic [15:0] a_alu_out;
  logic        a_rsp_valid, a_rsp_ready;
  logic [1:0]  a_rsp_id;
  logic [15:0] a_rsp_data;
  logic        a_busy;

  alu_req_arbiter #(.NUM_REQ(N), .OP_W(8), .OPC_W(3), .RES_W(16), .ALU_LAT(LAT_A)) dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_operand_a(a_opa), .req_operand_b(a_opb), .req_opcode(a_opc),
    .alu_load_en(a_load_en), .alu_operand_a(a_alu_a), .alu_operand_b(a_alu_b),
    .alu_opcode(a_alu_op), .alu_out(a_alu_out), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .busy(a_busy));

  // ---------------- instance B (ALU_LAT=4) ----------------
  logic        b_reset;
  logic [3:0]  b_req_valid, b_req_ready;
  logic [31:0] b_opa, b_opb;
  logic [11:0] b_opc;
  logic        b_load_en;
  logic [7:0]  b_alu_a, b_alu_b;
  logic [2:0]  b_alu_op;
  logic [15:0] b_alu_out;
  logic        b_rsp_valid, b_rsp_ready;
  logic [1:0]  b_rsp_id;
  logic [15:0] b_rsp_data;
  logic        b_busy;

  alu_req_arbiter #(.NUM_REQ(N), .OP_W(8), .OPC_W(3), .RES_W(16), .ALU_LAT(LAT_B)) dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_operand_a(b_opa), .req_operand_b(b_opb), .req_opcode(b_opc),
    .alu_load_en(b_load_en), .alu_operand_a(b_alu_a), .alu_operand_b(b_alu_b),
    .alu_opcode(b_alu_op), .alu_out(b_alu_out), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .busy(b_busy));

  // Behavioural ALU: result only appears exactly LAT cycles after load_en is
  // sampled; every other cycle shows a filler value.
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: alu_f = {8'h00, a} + {8'h00, b};
      3'd1: alu_f = {8'h00, a} - {8'h00, b};
      3'd2: alu_f = {8'h00, a & b};
      3'd3: alu_f = {8'h00, a | b};
      3'd4: alu_f = {8'h00, a ^ b};
      3'd5: alu_f = {8'h00, a} * {8'h00, b};
      3'd6: alu_f = {8'h00, a} << b[3:0];
      default: alu_f = {a, b};
    endcase
  endfunction

  logic [15:0] a_pipe [LAT_A];
  logic [15:0] b_pipe [LAT_B];
  always @(posedge clk) begin
    a_pipe[0] <= a_load_en ? alu_f(a_alu_a, a_alu_b, a_alu_op) : 16'hBAD0;
    for (int k = 1; k < LAT_A; k++) a_pipe[k] <= a_pipe[k-1];
    b_pipe[0] <= b_load_en ? alu_f(b_alu_a, b_alu_b, b_alu_op) : 16'hBAD0;
    for (int k = 1; k < LAT_B; k++) b_pipe[k] <= b_pipe[k-1];
  end
  assign a_alu_out = a_pipe[LAT_A-1];
  assign b_alu_out = b_pipe[LAT_B-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration rule: first valid after last, wrapping.
  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [1:0]  id;
    logic [15:0] data;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input vec_t v, input int n);
    string s;
    s = $sformatf("vec%0d", n);
    a_req_valid = v.valid;
    for (int i = 0; i < 4; i++) begin
      a_opa[i*8 +: 8] = 8'($urandom);
      a_opb[i*8 +: 8] = 8'($urandom);
      a_opc[i*3 +: 3] = 3'($urandom);
    end
    a_opa[v.id*8 +: 8] = v.a;
    a_opb[v.id*8 +: 8] = v.b;
    a_opc[v.id*3 +: 3] = v.op;
    @(negedge clk);
    chk({s, "_ready"}, a_req_ready, 4'b0001 << v.id);
    chk({s, "_busy0"}, a_busy, 0);
    next_cycle;
    a_req_valid = 4'b0000;
    @(negedge clk);
    chk({s, "_load1"}, a_load_en, 1);
    chk({s, "_opa"}, a_alu_a, v.a);
    chk({s, "_opb"}, a_alu_b, v.b);
    chk({s, "_opc"}, a_alu_op, v.op);
    next_cycle;
    @(negedge clk);
    chk({s, "_load0"}, a_load_en, 0);
    chk({s, "_rspv0"}, a_rsp_valid, 0);
    next_cycle;
    @(negedge clk);
    chk({s, "_rspv1"}, a_rsp_valid, 1);
    chk({s, "_rspid"}, a_rsp_id, v.id);
    chk({s, "_rspdata"}, a_rsp_data, v.data);
    next_cycle;
    @(negedge clk);
    chk({s, "_idle"}, a_busy, 0);
    chk({s, "_rspv_clr"}, a_rsp_valid, 0);
    chk({s, "_data_hold"}, a_rsp_data, v.data);
    next_cycle;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g [6];
    int le [6];
    int ng, nl, n;
    logic [15:0] lat_exp [8];

    tbl[0] = '{4'b0100, 8'h12, 8'h34, 3'd0, 2'd2, 16'h0046};
    tbl[1] = '{4'b1111, 8'h05, 8'h07, 3'd1, 2'd3, 16'hFFFE};
    tbl[2] = '{4'b0001, 8'hF0, 8'h3C, 3'd2, 2'd0, 16'h0030};
    tbl[3] = '{4'b0001, 8'hF0, 8'h0F, 3'd3, 2'd0, 16'h00FF};
    tbl[4] = '{4'b1001, 8'hA5, 8'hFF, 3'd4, 2'd3, 16'h005A};
    tbl[5] = '{4'b1010, 8'h10, 8'h10, 3'd5, 2'd1, 16'h0100};
    tbl[6] = '{4'b0101, 8'h81, 8'h04, 3'd6, 2'd2, 16'h0810};
    tbl[7] = '{4'b1011, 8'hDE, 8'hAD, 3'd7, 2'd3, 16'hDEAD};
    lat_exp = '{16'h0100, 16'h00FE, 16'h0001, 16'h00FF, 16'h00FE, 16'h00FF, 16'h01FE, 16'hFF01};

    // reset
    a_reset = 1'b1; b_reset = 1'b1;
    a_req_valid = 4'hF; b_req_valid = 4'hF;
    a_opa = '0; a_opb = '0; a_opc = '0; b_opa = '0; b_opb = '0; b_opc = '0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    next_cycle;
    next_cycle;
    @(negedge clk);
    chk("rst_ready_a", a_req_ready, 0);
    chk("rst_ready_b", b_req_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_load", a_load_en, 0);
    chk("rst_rspv", a_rsp_valid, 0);
    chk("rst_opa", a_alu_a, 0);
    chk("rst_opb", a_alu_b, 0);
    chk("rst_opc", a_alu_op, 0);
    chk("rst_rspid", a_rsp_id, 0);
    chk("rst_rspdata", a_rsp_data, 0);
    next_cycle;
    a_req_valid = 4'h0; b_req_valid = 4'h0;
    a_reset = 1'b0; b_reset = 1'b0;
    next_cycle;

    // table-driven single transactions
    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // round robin with all four valid
    a_req_valid = 4'hF;
    ng = 0; nl = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (a_load_en && nl < 6) begin le[nl] = c; nl++; end
      if (a_req_ready != 0) begin g[ng] = oh_idx(a_req_ready); ng++; end
      next_cycle;
    end
    chk("rr_count", ng, 6);
    for (int i = 0; i < ng; i++) chk($sformatf("rr_grant%0d", i), g[i], i % 4);
    for (int i = 1; i < nl; i++) chk($sformatf("rr_spacing%0d", i), le[i] - le[i-1], 4);
    a_req_valid = 4'h0;
    repeat (4) next_cycle;

    // backpressure with a late arrival from requester 3 during WAIT
    a_rsp_ready = 1'b0;
    a_req_valid = 4'b0001;
    a_opa[7:0] = 8'h33; a_opb[7:0] = 8'h11; a_opc[2:0] = 3'd1;
    @(negedge clk);
    chk("bp_ready", a_req_ready, 4'b0001);
    next_cycle;
    a_req_valid = 4'b0000;
    next_cycle;
    a_req_valid = 4'b1000;
    a_opa[31:24] = 8'h02; a_opb[31:24] = 8'h03; a_opc[11:9] = 3'd5;
    @(negedge clk);
    chk("late_ready_wait", a_req_ready, 0);
    next_cycle;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), a_rsp_valid, 1);
      chk($sformatf("bp_id%0d", k), a_rsp_id, 0);
      chk($sformatf("bp_data%0d", k), a_rsp_data, 16'h0022);
      chk($sformatf("bp_ready%0d", k), a_req_ready, 0);
      chk($sformatf("bp_busy%0d", k), a_busy, 1);
      next_cycle;
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", a_rsp_valid, 1);
    next_cycle;
    @(negedge clk);
    chk("bp_idle", a_busy, 0);
    chk("late_grant3", a_req_ready, 4'b1000);
    next_cycle;
    a_req_valid = 4'b0000;
    next_cycle;
    next_cycle;
    @(negedge clk);
    chk("late_rspid", a_rsp_id, 3);
    chk("late_rspdata", a_rsp_data, 16'h0006);
    next_cycle;

    // withdrawal: requester 1 drops while 0 is served
    a_req_valid = 4'b0011;
    @(negedge clk);
    chk("wd_grant0", a_req_ready, 4'b0001);
    next_cycle;
    a_req_valid = 4'b0100;
    repeat (3) next_cycle;
    @(negedge clk);
    chk("wd_skip1", a_req_ready, 4'b0100);
    next_cycle;
    a_req_valid = 4'b0000;
    repeat (4) next_cycle;

    // latency parameter on instance B, every opcode with FF/01
    for (int op = 0; op < 8; op++) begin
      b_req_valid = 4'b0010;
      b_opa[15:8] = 8'hFF; b_opb[15:8] = 8'h01; b_opc[5:3] = 3'(op);
      @(negedge clk);
      chk($sformatf("lat_ready_op%0d", op), b_req_ready, 4'b0010);
      n = 0;
      for (int c = 0; c < 15; c++) begin
        next_cycle;
        b_req_valid = 4'b0000;
        n++;
        @(negedge clk);
        if (b_rsp_valid) break;
        chk($sformatf("lat_load_op%0d_c%0d", op, n), b_load_en, (n == 1) ? 1 : 0);
      end
      chk($sformatf("lat_cycles_op%0d", op), n, 6);
      chk($sformatf("lat_data_op%0d", op), b_rsp_data, lat_exp[op]);
      next_cycle;
    end

    // reset in WAIT on instance B
    b_req_valid = 4'b0001;
    @(negedge clk);
    chk("rw_grant0", b_req_ready, 4'b0001);
    next_cycle;
    b_req_valid = 4'b0000;
    next_cycle;
    next_cycle;
    b_reset = 1'b1;
    next_cycle;
    b_reset = 1'b0;
    @(negedge clk);
    chk("rw_busy", b_busy, 0);
    chk("rw_load", b_load_en, 0);
    chk("rw_rspv", b_rsp_valid, 0);
    chk("rw_opa", b_alu_a, 0);
    chk("rw_opb", b_alu_b, 0);
    chk("rw_opc", b_alu_op, 0);
    chk("rw_rspid", b_rsp_id, 0);
    chk("rw_rspdata", b_rsp_data, 0);
    for (int k = 0; k < 8; k++) begin
      next_cycle;
      @(negedge clk);
      chk($sformatf("rw_norsp%0d", k), b_rsp_valid, 0);
      chk($sformatf("rw_noload%0d", k), b_load_en, 0);
    end
    next_cycle;
    b_req_valid = 4'b0011;
    @(negedge clk);
    chk("rw_regrant0", b_req_ready, 4'b0001);
    next_cycle;
    b_req_valid = 4'b0000;
    repeat (8) next_cycle;

    // randomized run on instance A against a transaction-level model
    a_reset = 1'b1;
    a_req_valid = 4'h0;
    next_cycle;
    a_reset = 1'b0;
    begin
      int last, acc, pid, k, w;
      bit pend;
      logic [7:0] ha, hb, pa, pb;
      logic [2:0] hop, pop;
      logic [1:0] hid;
      logic [15:0] hdata, pdata;
      logic [3:0] gprev;
      last = 3; pend = 0; acc = 0; pid = 0;
      ha = 0; hb = 0; hop = 0; hid = 0; hdata = 0;
      pa = 0; pb = 0; pop = 0; pdata = 0;
      gprev = 4'h0;
      for (int c = 0; c < 3000; c++) begin
        a_rsp_ready = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < 4; i++) begin
          if (a_req_valid[i] && !gprev[i]) begin
            if ($urandom_range(0, 9) == 0) a_req_valid[i] = 1'b0;
          end else begin
            a_req_valid[i] = ($urandom_range(0, 2) == 0);
            a_opa[i*8 +: 8] = 8'($urandom);
            a_opb[i*8 +: 8] = 8'($urandom);
            a_opc[i*3 +: 3] = 3'($urandom);
          end
        end
        @(negedge clk);
        chk("rnd_opa", a_alu_a, ha);
        chk("rnd_opb", a_alu_b, hb);
        chk("rnd_opc", a_alu_op, hop);
        chk("rnd_rspid", a_rsp_id, hid);
        if (!pend) begin
          w = rr_pick(last, a_req_valid);
          chk("rnd_ready", a_req_ready, (w < 0) ? 4'b0 : (4'b0001 << w));
          chk("rnd_busy", a_busy, 0);
          chk("rnd_load", a_load_en, 0);
          chk("rnd_rspv", a_rsp_valid, 0);
          chk("rnd_data", a_rsp_data, hdata);
          if (w >= 0) begin
            pend = 1; acc = c; pid = w; last = w;
            pa = a_opa[w*8 +: 8]; pb = a_opb[w*8 +: 8]; pop = a_opc[w*3 +: 3];
            pdata = alu_f(pa, pb, pop);
            ha = pa; hb = pb; hop = pop; hid = 2'(w);
          end
        end else begin
          k = c - acc;
          chk("rnd_ready", a_req_ready, 0);
          chk("rnd_busy", a_busy, 1);
          chk("rnd_load", a_load_en, (k == 1) ? 1 : 0);
          chk("rnd_rspv", a_rsp_valid, (k >= 2 + LAT_A) ? 1 : 0);
          chk("rnd_data", a_rsp_data, hdata);
          if (k == 1 + LAT_A) hdata = pdata;
          if (k >= 2 + LAT_A && a_rsp_ready) pend = 0;
        end
        gprev = a_req_ready;
        next_cycle;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
